// File: rtl/ram_tdp_be.sv
// rtl/ram_tdp_be.sv - true dual-port RAM with byte enables, read-during-write modes and collision pulse
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   en_x, wen_x                  port x access enable and write select (x = a, b)
//   bwen_x, addr_x, din_x        port x byte enables, word address, write data
//   dout_x, vld_x                port x read data and one-cycle read-valid strobe
//   coll                         one-cycle pulse after a same-address access with a write
module ram_tdp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_a,
  input  logic                  wen_a,
  input  logic [BWEN_WIDTH-1:0] bwen_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  vld_a,
  input  logic                  en_b,
  input  logic                  wen_b,
  input  logic [BWEN_WIDTH-1:0] bwen_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  vld_b,
  output logic                  coll
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a, rd_a, inr_a;
  logic                  wr_b, rd_b, inr_b;
  logic                  same;
  logic                  coll_d;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] new_a, new_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  rvld_a, rvld_b;

  always_comb begin
    wr_a  = en_a & wen_a;
    rd_a  = en_a & ~wen_a;
    wr_b  = en_b & wen_b;
    rd_b  = en_b & ~wen_b;
    inr_a = ({1'b0, addr_a} < DEPTH_LIM);
    inr_b = ({1'b0, addr_b} < DEPTH_LIM);
    same  = en_a & en_b & inr_a & inr_b & (addr_a == addr_b);
    coll_d = same & (wen_a | wen_b);

    old_a = inr_a ? mem[addr_a] : '0;
    old_b = inr_b ? mem[addr_b] : '0;

    // Each port's new word folds in the other port's bytes when both hit the
    // same word, so the two stores agree. Port A wins shared bytes.
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BWEN_WIDTH; i++) begin
      if (same && wr_b && bwen_b[i]) new_a[8*i +: 8] = din_b[8*i +: 8];
      if (wr_a && bwen_a[i])         new_a[8*i +: 8] = din_a[8*i +: 8];
      if (wr_b && bwen_b[i])         new_b[8*i +: 8] = din_b[8*i +: 8];
      if (same && wr_a && bwen_a[i]) new_b[8*i +: 8] = din_a[8*i +: 8];
    end

    // A reading port always sees the pre-write word, even under collision.
    rdata_a = old_a;
    rvld_a  = rd_a;
    if (wr_a) begin
      if (RD_MODE == 1) begin
        rvld_a  = 1'b1;
        rdata_a = inr_a ? new_a : '0;
      end else if (RD_MODE == 0) begin
        rvld_a  = 1'b1;
      end
    end

    rdata_b = old_b;
    rvld_b  = rd_b;
    if (wr_b) begin
      if (RD_MODE == 1) begin
        rvld_b  = 1'b1;
        rdata_b = inr_b ? new_b : '0;
      end else if (RD_MODE == 0) begin
        rvld_b  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem  <= '{default: '0};
      coll <= 1'b0;
    end else begin
      if (wr_a && inr_a) mem[addr_a] <= new_a;
      if (wr_b && inr_b) mem[addr_b] <= new_b;
      coll <= coll_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] pipe_data_a, pipe_data_b;
      logic                  pipe_vld_a, pipe_vld_b;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pipe_data_a <= '0;
          pipe_data_b <= '0;
          pipe_vld_a  <= 1'b0;
          pipe_vld_b  <= 1'b0;
          dout_a      <= '0;
          dout_b      <= '0;
          vld_a       <= 1'b0;
          vld_b       <= 1'b0;
        end else begin
          pipe_vld_a <= rvld_a;
          pipe_vld_b <= rvld_b;
          if (rvld_a) pipe_data_a <= rdata_a;
          if (rvld_b) pipe_data_b <= rdata_b;
          vld_a <= pipe_vld_a;
          vld_b <= pipe_vld_b;
          if (pipe_vld_a) dout_a <= pipe_data_a;
          if (pipe_vld_b) dout_b <= pipe_data_b;
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          dout_a <= '0;
          dout_b <= '0;
          vld_a  <= 1'b0;
          vld_b  <= 1'b0;
        end else begin
          vld_a <= rvld_a;
          vld_b <= rvld_b;
          if (rvld_a) dout_a <= rdata_a;
          if (rvld_b) dout_b <= rdata_b;
        end
      end
    end
  endgenerate

endmodule

// File: doc/ram_tdp_be.md
# ram_tdp_be

True dual-port synchronous RAM with per-byte write enables on both ports, a selectable read-during-write mode, an optional output pipeline stage, read-valid strobes and cross-port collision reporting. It is the general-purpose successor to the team's fixed dual-port RAM. It serves as the storage primitive under FIFOs, register files and DMA buffers where two independent agents share one array.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- RD_MODE, 0, same-port read-during-write mode: 0 = read-first, 1 = write-first, 2 = no-change.
- OUT_REG, 0, 1 adds an output register stage.
- ADDR_WIDTH (local), $clog2(DEPTH).
- BWEN_WIDTH (local), DATA_WIDTH/8.

Ports:
- clock  in  1  clock, rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- en_a  in  1  port A access enable.
- wen_a  in  1  port A write (qualified by en_a).
- bwen_a  in  BWEN_WIDTH  port A byte enables; bit i covers din_a[8i+7:8i].
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data.
- vld_a  out  1  port A read data valid, one-cycle pulse per read.
- en_b, wen_b, bwen_b, addr_b, din_b, dout_b, vld_b: port B, identical to port A.
- coll  out  1  registered collision pulse.

## Operation
- Reset clears every memory word, dout_a, dout_b, vld_a, vld_b, coll and any pipeline registers to 0. Reset takes effect immediately and discards in-flight reads.
- Write cycle: en && wen. Every byte with bwen=1 is updated; other bytes hold. A write cycle with bwen all zero changes nothing but still counts as a write for RD_MODE.
- Read cycle: en && !wen. The read captures the full word at addr.
- Same-port write cycle, by RD_MODE:
  - 0: the port also returns the old word and pulses vld.
  - 1: the port returns the merged new word and pulses vld.
  - 2: dout holds and vld stays 0.
- Out-of-range address (addr >= DEPTH): writes are ignored; reads return 0 with vld asserted.
- Cross-port collision: both ports are enabled, addr_a == addr_b (in range), and at least one port writes.
  - Write/write: bytes enabled on only one port take that port's data. Bytes enabled on both take port A's data.
  - Read/write: the reading port returns the pre-write word, regardless of RD_MODE.
  - coll pulses 1 for one cycle, one cycle after the collision edge.
- dout holds its last value when no read completes. vld is 0 in every cycle without a completing read.
- en=0: the port is idle; no memory access and no vld.

## Timing
- Read latency is 1 + OUT_REG cycles from the issuing edge to dout/vld.
  - OUT_REG=0: dout/vld update on the edge that samples the request.
  - OUT_REG=1: dout/vld update one edge later.
- Fully pipelined: one request per port per cycle; back-to-back reads give consecutive vld pulses.
- Write data is visible to a read issued on the following cycle, on either port.
- coll appears exactly one cycle after the colliding edge, independent of OUT_REG.
- Asserting reset mid-pipeline clears pending vld; no stale vld appears after release.
- The first access is accepted on the first rising edge after reset deasserts.

## Test plan
- Reset, then read addr 0..15 on both ports -> all dout = 0; vld pulses one per read at latency 1+OUT_REG.
- Port A writes 0xAABBCCDD to addr 3 with bwen_a=4'b1111. Port B then writes 0x11223344 to addr 3 with bwen_b=4'b0101. Read addr 3 -> 0xAA22CC44.
- Same-port write of 0x12345678 over 0xDEADBEEF at addr 5, once per RD_MODE:
  - 0 -> dout=0xDEADBEEF, vld=1.
  - 1 -> dout=0x12345678, vld=1.
  - 2 -> dout unchanged, vld=0.
- Simultaneous write/write to addr 7: A writes 0xFFFF0000 with bwen 4'b1100; B writes 0x0000FFFF with bwen 4'b1110. Read addr 7 -> 0xFFFFFF00; coll=1 one cycle after the edge, then 0.
- Simultaneous A read / B write to addr 9 (old word 0x55) -> dout_a=0x55, coll=1. The next A read returns B's data.
- DEPTH=12, OUT_REG=1: write addr 13 (out of range), then read 13 -> dout=0 at latency 2. Words 0..11 are unchanged. Assert reset with a read in flight -> vld stays 0.
